// File: rtl/ps2_host_tx_if.sv
// Command/status bundle for the PS/2 host transmitter.
//   cmd_valid, cmd_data : command byte offered by the controller (LSB sent first)
//   cmd_ready           : transmitter idle and able to take a byte
//   tx_busy             : transfer in progress
//   tx_done, tx_error   : one-cycle completion / failure pulses
// master = controller side, slave = transmitter side.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// inhibit, request-to-send, 8 data bits on device clock falls, odd parity,
// stop, then checks the device ACK and waits for the bus to go idle.
// Ports:
//   CLOCK_50   : system clock, all logic on the rising edge
//   reset      : synchronous, active-high
//   cmd        : command handshake and status (ps2_host_tx_if.slave)
//   ps2_clk_in : raw PS2_CLK pad level
//   ps2_dat_in : raw PS2_DAT pad level
//   ps2_clk_oe : 1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe : 1 = pull PS2_DAT low, 0 = release
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StRts      = 3'd2;
  localparam logic [2:0] StSend     = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;
  localparam logic [2:0] StErr      = 3'd7;

  // One counter serves both the inhibit interval and the event timeout.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            dat_s1_q, dat_s2_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [9:0]      shift_q, shift_d;
  logic            dat_oe_q, dat_oe_d;

  logic            clk_fall;
  logic            timeout;
  logic [CntW-1:0] cnt_inc;

  assign clk_fall = clk_prev_q & ~clk_s2_q;
  assign timeout  = (cnt_q == TimeoutLast);
  // Saturating increment: the timer must never wrap back to zero.
  assign cnt_inc  = timeout ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    dat_oe_d  = dat_oe_q;

    case (state_q)
      StIdle: begin
        dat_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_idx_d = '0;
        if (cmd.cmd_valid) begin
          // {stop, odd parity, data}; shifted out LSB first.
          shift_d = {1'b1, ~^cmd.cmd_data, cmd.cmd_data};
          state_d = StInhibit;
        end
      end

      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;  // start bit goes low while clock is still held
          state_d  = StRts;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRts: begin
        cnt_d   = '0;
        state_d = StSend;
      end

      StSend: begin
        if (clk_fall) begin
          cnt_d     = '0;
          dat_oe_d  = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            state_d = StAck;
          end
        end else if (timeout) begin
          dat_oe_d = 1'b0;
          state_d  = StErr;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StAck: begin
        if (clk_fall) begin
          cnt_d   = '0;
          state_d = dat_s2_q ? StErr : StWaitIdle;
        end else if (timeout) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StWaitIdle: begin
        if (clk_s2_q && dat_s2_q) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StDone: begin
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end

      StErr: begin
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      dat_oe_q   <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      dat_oe_q   <= dat_oe_d;
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign cmd.tx_busy   = (state_q != StIdle);
  assign cmd.tx_done   = (state_q == StDone);
  assign cmd.tx_error  = (state_q == StErr);
  assign ps2_clk_oe    = (state_q == StInhibit) || (state_q == StRts);
  assign ps2_dat_oe    = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic) from the synth controller to the keyboard.
- Performs the inhibit / request-to-send sequence, shifts data on device-generated clock edges, appends odd parity and stop, and checks the device ACK.
- Sits beside the scancode receiver on the same PS2_CLK/PS2_DAT pair; the top level implements the open-drain pads from this block's drive-enables.

Parameters:
- INHIBIT_CYCLES, 5000, cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max cycles between expected device clock falls before abort (15 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command byte offered.
- cmd_data  in  8  command byte, LSB sent first.
- cmd_ready  out  1  high only in IDLE; transfer accepted when cmd_valid && cmd_ready.
- ps2_clk_in  in  1  raw PS2_CLK pad level.
- ps2_dat_in  in  1  raw PS2_DAT pad level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (Z).
- ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release (Z).
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and ACKed.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cmd_ready=1, ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters=0.
  - Synchronizer flops reset to 1.
  - Reset mid-transfer releases both lines on the next edge and discards the byte; no done/error pulse.
- Inputs pass through 2-flop synchronizers. clk_fall = previous synced clk 1 && current synced clk 0.
- Shift register (10 bits) latched on accept: {stop=1, parity=~^cmd_data, cmd_data}. Parity is odd: 0xED->1, 0x01->0, 0x00->1, 0xFF->1.
- IDLE:
  - cmd_ready=1; both oe=0.
  - On accept: latch byte, go INHIBIT.
  - cmd_valid while not IDLE is ignored; it is not queued.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; clk_fall ignored.
  - Then go RTS.
- RTS:
  - One cycle with ps2_clk_oe=1 and ps2_dat_oe=1 (start bit 0), so data falls before clock release.
  - Then go SEND with ps2_clk_oe=0 and ps2_dat_oe held 1.
- SEND:
  - Bit index k=0..9. On each clk_fall: ps2_dat_oe <= ~shift[k]; k++.
  - k=0..7 present data bits, k=8 parity, k=9 releases data (stop=1).
  - The timeout counter clears on each clk_fall.
  - After the 10th clk_fall, go ACK.
- ACK:
  - On the next clk_fall, sample synced data.
  - Data 0: go WAIT_IDLE.
  - Data 1: go ERR (no ACK).
- WAIT_IDLE:
  - Wait until synced clk=1 and synced data=1 on the same cycle.
  - Then pulse tx_done for 1 cycle and return to IDLE; cmd_ready=1 on the cycle after the pulse.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, if TIMEOUT_CYCLES elapse without the awaited event, go ERR.
  - The counter saturates; it must not wrap.
- ERR: release both lines, pulse tx_error for 1 cycle, return to IDLE.
- Done and error pulses are mutually exclusive and never coincide with cmd_ready=1.
- Spurious device clock activity in IDLE is ignored; the block never drives a line outside a transfer.

Test Plan (bench: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200; device model clocks at 40-cycle half-period, samples data on clock rise):
- Send 0xED, device ACKs:
  - ps2_clk_oe high exactly 10 cycles (+1 RTS cycle).
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once after lines idle; tx_error stays 0.
- Send 0x01 then 0xFF back-to-back (cmd_valid held):
  - Parities 0 and 1.
  - Second byte accepted only after first tx_done, when cmd_ready returns to 1.
- Device model does not pull data low at the ACK clock:
  - tx_error pulses one cycle; both oe=0; tx_done never asserts.
- Device never clocks after RTS:
  - tx_error pulses exactly 200 cycles after SEND entry.
  - ps2_dat_oe released; cmd_ready=1 on the following cycle.
- Assert reset after the 4th device clock fall of 0x00:
  - Next cycle both oe=0, tx_busy=0, cmd_ready=1, no pulses.
  - A new 0x00 then completes with parity 1.
- Toggle ps2_clk_in in IDLE, and pulse cmd_valid during SEND:
  - No line driven in IDLE.
  - The in-flight byte is unaffected; the extra cmd_valid is not transmitted.
